// File: rtl/intrp_arb_pkg.sv
// Shared types and constants for the action interrupt arbiter and its round-robin picker.
package intrp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    localparam int DEF_SRC_W = 64;
    localparam int DEF_CTX_W = 9;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first eligible bit after last_grant_i, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  eligible_i,
    input  logic [IW-1:0] last_grant_i,
    output logic [IW-1:0] grant_o,
    output logic          valid_o
);

    always_comb begin
        int idx;
        idx     = 0;
        grant_o = '0;
        valid_o = 1'b0;
        // Offsets 1..N visit every requester once, ending on last_grant itself.
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_grant_i) + i) % N;
            if (!valid_o && eligible_i[IW'(idx)]) begin
                valid_o = 1'b1;
                grant_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/intrp_arbiter.sv
// Round-robin sharing of the single action interrupt channel among NUM_REQ requesters.
// Optional ack watchdog enabled by defining INTRP_ARB_TIMEOUT_EN.
module intrp_arbiter
    import intrp_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = DEF_SRC_W,
    parameter int CTX_W   = DEF_CTX_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                     action_clock,
    input  logic                     action_rst,
    input  logic [NUM_REQ-1:0]       up_en,
    input  logic [NUM_REQ-1:0]       up_req,
    input  logic [NUM_REQ*SRC_W-1:0] up_src,
    input  logic [NUM_REQ*CTX_W-1:0] up_ctx,
    output logic [NUM_REQ-1:0]       up_ack,
    output logic                     intrp_req,
    input  logic                     intrp_ack,
    output logic [SRC_W-1:0]         intrp_src,
    output logic [CTX_W-1:0]         intrp_ctx,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IW = idx_w(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      last_grant_q, last_grant_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [CTX_W-1:0]   ctx_q, ctx_d;
    logic [NUM_REQ-1:0] up_ack_q, up_ack_d;
    logic [IW-1:0]      pick;
    logic               pick_vld;
    logic               to_hit;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .eligible_i   (up_req & up_en),
        .last_grant_i (last_grant_q),
        .grant_o      (pick),
        .valid_o      (pick_vld)
    );

`ifdef INTRP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Counter sits at zero outside ISSUE, so it is already clear on entry.
    assign to_hit = (state_q == ISSUE) && (cnt_q == CW'(TIMEOUT - 1)) && !intrp_ack;
    assign cnt_d  = (state_q == ISSUE) ? cnt_q + 1'b1 : '0;
    assign err_d  = err_q | to_hit;

    always_ff @(posedge action_clock or posedge action_rst) begin
        if (action_rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign to_hit      = 1'b0;
    // TIMEOUT only matters with the watchdog built in.
    assign timeout_err = 1'b0 & (TIMEOUT != 0);
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        src_d        = src_q;
        ctx_d        = ctx_q;
        up_ack_d     = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d      = ISSUE;
                    grant_d      = pick;
                    last_grant_d = pick;
                    src_d        = up_src[int'(pick)*SRC_W +: SRC_W];
                    ctx_d        = up_ctx[int'(pick)*CTX_W +: CTX_W];
                end
            end
            ISSUE: begin
                if (intrp_ack || to_hit) begin
                    state_d           = DONE;
                    up_ack_d[grant_q] = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge action_clock or posedge action_rst) begin
        if (action_rst) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(NUM_REQ - 1);
            grant_q      <= '0;
            src_q        <= '0;
            ctx_q        <= '0;
            up_ack_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            src_q        <= src_d;
            ctx_q        <= ctx_d;
            up_ack_q     <= up_ack_d;
        end
    end

    assign up_ack    = up_ack_q;
    assign intrp_req = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign intrp_src = src_q;
    assign intrp_ctx = ctx_q;

endmodule

// File: tb/tb_intrp_arbiter.sv
// Self-checking bench for intrp_arbiter; grant order is checked through an expected-index queue.
module tb_intrp_arbiter;

    localparam int N  = 4;
    localparam int SW = 64;
    localparam int CW = 9;

    logic            action_clock = 1'b0;
    logic            action_rst   = 1'b1;
    logic [N-1:0]    up_en        = '0;
    logic [N-1:0]    up_req       = '0;
    logic [N*SW-1:0] up_src       = '0;
    logic [N*CW-1:0] up_ctx       = '0;
    logic [N-1:0]    up_ack;
    logic            intrp_req;
    logic            intrp_ack    = 1'b0;
    logic [SW-1:0]   intrp_src;
    logic [CW-1:0]   intrp_ctx;
    logic            busy;
    logic            timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [SW-1:0] src_tab [N];
    logic [CW-1:0] ctx_tab [N];
    logic [1:0]    exp_q[$];
    logic          req_prev = 1'b0;

    intrp_arbiter #(
        .NUM_REQ (N),
        .SRC_W   (SW),
        .CTX_W   (CW),
        .TIMEOUT (16)
    ) dut (
        .action_clock (action_clock),
        .action_rst   (action_rst),
        .up_en        (up_en),
        .up_req       (up_req),
        .up_src       (up_src),
        .up_ctx       (up_ctx),
        .up_ack       (up_ack),
        .intrp_req    (intrp_req),
        .intrp_ack    (intrp_ack),
        .intrp_src    (intrp_src),
        .intrp_ctx    (intrp_ctx),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    // clock / reset
    always #5 action_clock = ~action_clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // scoreboard: each rising intrp_req must match the next expected grant
    always @(negedge action_clock) begin
        if (intrp_req && !req_prev) begin
            if (exp_q.size() == 0) begin
                check("grant_unexpected", 64'd1, 64'd0);
            end else begin
                logic [1:0] idx;
                idx = exp_q.pop_front();
                check("grant_src", intrp_src, src_tab[idx]);
                check("grant_ctx", 64'(intrp_ctx), 64'(ctx_tab[idx]));
            end
        end
        req_prev = intrp_req;
    end

    // driver tasks
    task automatic do_reset();
        up_req     = '0;
        intrp_ack  = 1'b0;
        action_rst = 1'b1;
        repeat (2) @(posedge action_clock);
        #1 action_rst = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        @(negedge action_clock);
        while (!intrp_req && n < 50) begin
            @(negedge action_clock);
            n++;
        end
        if (!intrp_req) check("req_wait_timeout", 64'd0, 64'd1);
    endtask

    task automatic ack_and_check(input int d, input int idx, input bit drop);
        logic [N-1:0] oh;
        oh = N'(1) << idx;
        repeat (d) @(posedge action_clock);
        #1 intrp_ack = 1'b1;
        @(posedge action_clock);
        #1 intrp_ack = 1'b0;
        @(negedge action_clock);
        check("ack_pulse", 64'(up_ack), 64'(oh));
        check("ack_req_low", 64'(intrp_req), 64'd0);
        @(posedge action_clock);
        #1 if (drop) up_req[idx] = 1'b0;
        @(negedge action_clock);
        check("ack_one_cycle", 64'(up_ack), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            src_tab[i] = 64'hDEAD_0000_0000_0000 | 64'(i) | (64'(i) << 20);
            src_tab[i][2:0] = 3'(i);
        end
        src_tab[2] = 64'hDEAD_0000_0000_0002;
        ctx_tab[0] = 9'h003;
        ctx_tab[1] = 9'h01A;
        ctx_tab[2] = 9'h005;
        ctx_tab[3] = 9'h1FF;
        for (int i = 0; i < N; i++) begin
            up_src[i*SW +: SW] = src_tab[i];
            up_ctx[i*CW +: CW] = ctx_tab[i];
        end

        // reset state
        do_reset();
        @(negedge action_clock);
        check("rst_req", 64'(intrp_req), 64'd0);
        check("rst_ack", 64'(up_ack), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_src", intrp_src, 64'd0);
        check("rst_ctx", 64'(intrp_ctx), 64'd0);
        check("rst_terr", 64'(timeout_err), 64'd0);

        // single requester, latency, ack after 10 cycles
        up_en = '1;
        @(posedge action_clock);
        #1 exp_q.push_back(2'd2);
        up_req = 4'b0100;
        @(negedge action_clock);
        check("lat_cyc0", 64'(intrp_req), 64'd0);
        @(negedge action_clock);
        check("lat_cyc1", 64'(intrp_req), 64'd1);
        check("lat_busy", 64'(busy), 64'd1);
        ack_and_check(10, 2, 1'b1);

        // all four requesting continuously from reset
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back(2'(i % 4));
        up_req = 4'hF;
        for (int i = 0; i < 6; i++) begin
            wait_req();
            ack_and_check(2, i % 4, 1'b0);
        end
        up_req = '0;

        // only requesters 1 and 3 enabled
        do_reset();
        up_en = 4'b1010;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        up_req = 4'hF;
        for (int i = 0; i < 4; i++) begin
            wait_req();
            ack_and_check(2, (i % 2 == 0) ? 1 : 3, 1'b0);
        end
        up_req = '0;

        // all disabled stays idle; ack in IDLE ignored; ack coincident with grant ignored
        do_reset();
        up_en  = '0;
        up_req = 4'hF;
        repeat (5) @(posedge action_clock);
        @(negedge action_clock);
        check("en_off_busy", 64'(busy), 64'd0);
        up_req = '0;
        up_en  = '1;
        @(posedge action_clock);
        #1 intrp_ack = 1'b1;
        @(posedge action_clock);
        #1 intrp_ack = 1'b0;
        @(negedge action_clock);
        check("idle_ack_busy", 64'(busy), 64'd0);
        check("idle_ack_upack", 64'(up_ack), 64'd0);
        @(posedge action_clock);
        #1 exp_q.push_back(2'd0);
        up_req    = 4'b0001;
        intrp_ack = 1'b1;
        @(posedge action_clock);
        #1 intrp_ack = 1'b0;
        @(negedge action_clock);
        check("grant_ack_req", 64'(intrp_req), 64'd1);
        @(negedge action_clock);
        check("grant_ack_req2", 64'(intrp_req), 64'd1);
        check("grant_ack_upack", 64'(up_ack), 64'd0);
        ack_and_check(2, 0, 1'b1);

        // requester 1 drops request and enable mid-ISSUE
        @(posedge action_clock);
        #1 exp_q.push_back(2'd1);
        up_req[1] = 1'b1;
        wait_req();
        @(posedge action_clock);
        #1 up_req[1] = 1'b0;
        up_en[1] = 1'b0;
        up_src[SW +: SW] = 64'h0BAD_0BAD_0BAD_0BAD;
        up_ctx[CW +: CW] = 9'h0AA;
        repeat (3) @(posedge action_clock);
        @(negedge action_clock);
        check("drop_src_held", intrp_src, src_tab[1]);
        check("drop_ctx_held", 64'(intrp_ctx), 64'(ctx_tab[1]));
        check("drop_req_held", 64'(intrp_req), 64'd1);
        ack_and_check(2, 1, 1'b0);
        up_en = '1;
        up_src[SW +: SW] = src_tab[1];
        up_ctx[CW +: CW] = ctx_tab[1];

        // asynchronous reset mid-ISSUE, then requester 0 has priority again
        @(posedge action_clock);
        #1 exp_q.push_back(2'd0);
        up_req = 4'b0001;
        wait_req();
        #2 action_rst = 1'b1;
        #1;
        check("arst_req", 64'(intrp_req), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        up_req = '0;
        @(posedge action_clock);
        #1 action_rst = 1'b0;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        up_req = 4'b0011;
        wait_req();
        ack_and_check(2, 0, 1'b1);
        wait_req();
        ack_and_check(2, 1, 1'b1);

`ifdef INTRP_ARB_TIMEOUT_EN
        // no ack: watchdog fires at issue+16, late ack ignored, next requester served
        do_reset();
        exp_q.push_back(2'd0);
        up_req = 4'b0001;
        wait_req();
        repeat (15) @(negedge action_clock);
        check("to_not_yet", 64'(timeout_err), 64'd0);
        check("to_req_still", 64'(intrp_req), 64'd1);
        @(negedge action_clock);
        check("to_err_set", 64'(timeout_err), 64'd1);
        check("to_upack", 64'(up_ack), 64'd1);
        check("to_req_low", 64'(intrp_req), 64'd0);
        @(posedge action_clock);
        #1 exp_q.push_back(2'd1);
        up_req    = 4'b0010;
        intrp_ack = 1'b1;
        @(posedge action_clock);
        #1 intrp_ack = 1'b0;
        @(negedge action_clock);
        check("to_late_ack_req", 64'(intrp_req), 64'd1);
        check("to_late_ack_upack", 64'(up_ack), 64'd0);
        check("to_err_sticky", 64'(timeout_err), 64'd1);
        ack_and_check(2, 1, 1'b1);
`endif

        repeat (3) @(negedge action_clock);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/intrp_arbiter.md
Name: intrp_arbiter

Overview:
- Shares the single action-side interrupt channel (intrp_req/intrp_ack/intrp_src/intrp_ctx) between NUM_REQ independent interrupt requesters inside an action.
- Round-robin arbitration, one outstanding interrupt at a time. Selected source/context are latched and held stable until the channel acknowledges; the ack is then routed back to the winning requester.
- Sits between action engines and the action top-level interrupt ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- SRC_W, 64, interrupt source width
- CTX_W, 9, context (PASID) width
- TIMEOUT, 1024, cycles to wait for intrp_ack before flagging (only with optional feature)

Ports:
- action_clock  in  1  clock
- action_rst  in  1  asynchronous active-high reset
- up_en  in  NUM_REQ  per-requester enable; disabled requesters are never granted
- up_req  in  NUM_REQ  requester interrupt request; level, held until its up_ack
- up_src  in  NUM_REQ*SRC_W  per-requester source, slice i = bits [i*SRC_W +: SRC_W]
- up_ctx  in  NUM_REQ*CTX_W  per-requester context, same slicing
- up_ack  out  NUM_REQ  one-cycle ack pulse to the granted requester
- intrp_req  out  1  downstream request, held until intrp_ack
- intrp_ack  in  1  downstream acknowledge, one-cycle pulse
- intrp_src  out  SRC_W  latched source of granted requester
- intrp_ctx  out  CTX_W  latched context of granted requester
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky ack-timeout flag (tied 0 without the optional feature)

Behaviour:
- Clock and reset: one clock, action_clock. Reset is asynchronous and active-high on action_rst.
- Reset values:
  - Outputs: up_ack=0, intrp_req=0, intrp_src=0, intrp_ctx=0, busy=0, timeout_err=0.
  - Internal: state=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- FSM states:
  - IDLE: eligible = up_req & up_en. If eligible≠0, pick the first set bit scanning from last_grant+1, wrapping modulo NUM_REQ. Latch grant index, up_src/up_ctx slices into intrp_src/intrp_ctx, set intrp_req=1, set last_grant=grant, go ISSUE.
  - ISSUE: intrp_req=1; intrp_src/intrp_ctx held stable. On intrp_ack=1: intrp_req<=0, up_ack[grant]<=1, go DONE.
  - DONE: up_ack pulses for exactly this one cycle, then clears; go IDLE.
- Latency:
  - up_req rising in cycle 0 with state IDLE: intrp_req high in cycle 1.
  - intrp_ack in cycle k: up_ack[grant] high and intrp_req low in cycle k+1.
  - Earliest next grant is evaluated in cycle k+2.
- Requester contract: deassert up_req the cycle after sampling up_ack; up_src/up_ctx are only sampled at the grant edge.
- Round-robin: last_grant updates only on grant. A single continuously requesting source is granted back-to-back, one grant every ≥3 cycles.
- Boundary conditions:
  - up_req dropped or up_en cleared while in ISSUE: the transaction still completes and up_ack still pulses (no retraction).
  - intrp_ack in IDLE or DONE: ignored.
  - intrp_ack coincident with the grant cycle: ignored, because intrp_req is not yet visible.
  - up_en=0 for all requesters: stay IDLE.
  - Reset mid-ISSUE: intrp_req drops immediately and the latched transaction is discarded.

Optional Feature:
- Macro: INTRP_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and increments each ISSUE cycle.
  - When it reaches TIMEOUT, timeout_err sets (sticky until reset) and the FSM forces DONE, pulsing up_ack[grant] so the requester is released. intrp_req drops.
  - An intrp_ack arriving afterwards is ignored.
- Undefined: no counter; timeout_err tied 0; ISSUE waits indefinitely.

Decomposition:
- Package intrp_arb_pkg:
  - typedef enum for the FSM states {IDLE, ISSUE, DONE}.
  - Default width constants SRC_W=64, CTX_W=9.
  - function for the index width, $clog2(NUM_REQ).
- Sub-module rr_pick:
  - Combinational round-robin selector.
  - Inputs: eligible vector and last_grant. Outputs: grant index and valid.
  - Reusable by other action arbiters.

Test Plan:
- Single requester: up_req[2]=1, src=0xDEAD_0000_0000_0002, ctx=0x05 -> intrp_req high next cycle with exactly that src/ctx; intrp_ack after 10 cycles -> up_ack[2] pulses one cycle, intrp_req low the same cycle.
- All 4 requesting continuously from reset with ack 2 cycles after each intrp_req -> grant order 0,1,2,3,0,…; intrp_src matches the granted slice every transaction.
- up_en=4'b1010 with all up_req high -> only requesters 1 and 3 granted, alternating.
- Requester 1 drops up_req mid-ISSUE -> intrp_src/intrp_ctx unchanged; up_ack[1] still pulses on intrp_ack.
- action_rst asserted during ISSUE -> intrp_req and busy go 0 without waiting for a clock edge; after reset, requester 0 has first priority.
- With INTRP_ARB_TIMEOUT_EN, TIMEOUT=16, no intrp_ack -> timeout_err set at issue+16, up_ack pulses, a late intrp_ack is ignored, and the next requester is granted.
